// File: rtl/md_ctrl.sv
// Multiply/divide sequencer beside the EX-stage ALU: owns HI/LO and holds the pipeline
// for a fixed latency while a MULT/MULTU/DIV/DIVU result is pending.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  localparam logic [3:0] MulLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad = 4'(DIV_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] op_a_q, op_b_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic        sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  // Results come only from the latched operands, so input changes while busy are harmless.
  always_comb begin
    sgn    = ~op_q[0];
    a_neg  = sgn & op_a_q[31];
    b_neg  = sgn & op_b_q[31];
    a_mag  = a_neg ? -op_a_q : op_a_q;
    b_mag  = b_neg ? -op_b_q : op_b_q;
    b_safe = (op_b_q == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    prod   = {{32{a_neg}}, op_a_q} * {{32{b_neg}}, op_b_q};
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (op_q[1]) begin
      if (op_b_q == 32'd0) begin
        res_lo = 32'hFFFF_FFFF;
        res_hi = op_a_q;
      end else begin
        // Magnitude divide then re-sign; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
        res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        res_hi = a_neg ? -r_mag : r_mag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_q    <= md_op[1:0];
                op_a_q  <= rs_data;
                op_b_q  <= rt_data;
                cnt_q   <= md_op[1] ? DivLoad : MulLoad;
                state_q <= md_op[1] ? StDiv : StMul;
                busy_q  <= 1'b1;
              end
              3'd4:    hi_q <= rs_data;
              3'd5:    lo_q <= rs_data;
              default: ;
            endcase
          end
        end
        StMul, StDiv: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign md_stall = busy_q | (start & ~md_op[2]);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: stimulus queues expected HI/LO and busy length,
// a negedge monitor checks them when busy falls.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .rs_data(rs_data),
    .rt_data(rt_data), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO on each busy fall.
  int  run = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      run = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) run++;
      else if (prev_busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_busy_cycles"}, run, e.cyc);
        end
        run = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic expect_res(input string name, input logic [31:0] h, input logic [31:0] l,
                            input int cyc);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Drive one command for one edge; md_stall is checked while it is held in idle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    #1 chk("md_stall_issue", {31'b0, md_stall}, (op <= 3'd3) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 40) chk("wait_idle_timeout", {31'b0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", {31'b0, md_stall}, 32'd0);
    @(negedge clk); reset = 1'b1;

    expect_res("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_idle();

    // MULTU with a DIV attempt at T+2 that must be ignored
    expect_res("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd2; rs_data = 32'd64; rt_data = 32'd8;
    #1 chk("md_stall_busy", {31'b0, md_stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    expect_res("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();

    expect_res("divu_zero", 32'd7, 32'hFFFF_FFFF, 10);
    issue(3'd3, 32'd7, 32'd0);
    wait_idle();

    expect_res("div_ovf", 32'd0, 32'h8000_0000, 10);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    expect_res("div_negdivisor", 32'd1, 32'hFFFF_FFFD, 10);
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle();

    expect_res("divu_big", 32'h0000_000F, 32'h0FFF_FFFF, 10);
    issue(3'd3, 32'hFFFF_FFFF, 32'd16);
    wait_idle();

    expect_res("mult_carry", 32'd1, 32'd0, 5);
    issue(3'd0, 32'h0001_0000, 32'h0001_0000);
    wait_idle();

    expect_res("div_zero_signed", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 10);
    issue(3'd2, 32'hFFFF_FFF0, 32'd0);
    wait_idle();

    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'b0, busy}, 32'd0);

    issue(3'd5, 32'hCAFE_BABE, 32'd0);
    chk("mtlo_lo", lo, 32'hCAFE_BABE);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);

    issue(3'd6, 32'h5555_5555, 32'd0);
    chk("rsvd_hi", hi, 32'h1234_5678);
    chk("rsvd_lo", lo, 32'hCAFE_BABE);
    chk("rsvd_busy", {31'b0, busy}, 32'd0);

    // MULT aborted by asynchronous reset between edges
    issue(3'd0, 32'd5, 32'd5);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk); #2 reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_abort_hi", hi, 32'd0);
    chk("post_abort_lo", lo, 32'd0);
    chk("post_abort_busy", {31'b0, busy}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
